// File: rtl/mdr_pkg.sv
// -----------------------------------------------------------------------------
// mdr_pkg
// Shared types and helpers for the memory data register (mdr_handshake).
//   mdr_state_e : handshake FSM states (IDLE, RD_WAIT, WR_WAIT)
//   SZ_*        : access size codes carried on the 'size' input
//   size_bytes  : number of bytes touched by an access of a given size
//   be_mask     : byte-enable pattern for a size at a byte offset (8 lanes max)
// No ports (package).
// -----------------------------------------------------------------------------
package mdr_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RD_WAIT = 2'b01,
      WR_WAIT = 2'b10
   } mdr_state_e;

   localparam logic [1:0] SZ_BYTE  = 2'b00;
   localparam logic [1:0] SZ_HALF  = 2'b01;
   localparam logic [1:0] SZ_WORD  = 2'b10;
   localparam logic [1:0] SZ_DWORD = 2'b11;

   function automatic logic [3:0] size_bytes(input logic [1:0] sz);
      case (sz)
         SZ_BYTE: return 4'd1;
         SZ_HALF: return 4'd2;
         SZ_WORD: return 4'd4;
         default: return 4'd8;
      endcase
   endfunction

   // Mask is built on the widest (8-lane) memory word; callers with fewer
   // lanes look at the bits above their lane count to detect overhang.
   function automatic logic [7:0] be_mask(input logic [1:0] sz, input logic [2:0] off);
      logic [7:0] base;
      case (sz)
         SZ_BYTE: base = 8'h01;
         SZ_HALF: base = 8'h03;
         SZ_WORD: base = 8'h0F;
         default: base = 8'hFF;
      endcase
      return base << off;
   endfunction

endpackage

// File: rtl/mdr_extend.sv
// -----------------------------------------------------------------------------
// mdr_extend
// Combinational load path: shifts the addressed byte lane down to bit 0 and
// sign- or zero-extends the access to the full register width.
// Ports:
//   data_i      in  DATA_W  raw memory word
//   size_i      in  2       access size code (SZ_*)
//   sign_ext_i  in  1       1 = sign-extend, 0 = zero-extend
//   lane_off_i  in  LANE_W  byte offset of the access within the word
//   data_o      out DATA_W  extracted and extended value
// -----------------------------------------------------------------------------
module mdr_extend
   import mdr_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int LANE_W = $clog2(DATA_W/8)
) (
   input  logic [DATA_W-1:0] data_i,
   input  logic [1:0]        size_i,
   input  logic              sign_ext_i,
   input  logic [LANE_W-1:0] lane_off_i,
   output logic [DATA_W-1:0] data_o
);

   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] low_mask;
   logic [DATA_W-1:0] msb_mask;
   logic              fill;
   int                nbits;

   always_comb begin
      shifted = data_i >> {lane_off_i, 3'b000};
      nbits   = 8 * int'(size_bytes(size_i));
      if (nbits > DATA_W) nbits = DATA_W;
      for (int i = 0; i < DATA_W; i++) begin
         low_mask[i] = (i < nbits);
         msb_mask[i] = (i == nbits - 1);
      end
      // The access MSB is picked with a one-hot mask rather than a variable
      // index so the index width never depends on DATA_W.
      fill   = sign_ext_i & (|(shifted & msb_mask));
      data_o = (shifted & low_mask) | (fill ? ~low_mask : '0);
   end

endmodule

// File: rtl/mdr_handshake.sv
// -----------------------------------------------------------------------------
// mdr_handshake
// Memory data register with integrated memory handshake. Loads from the bus
// (MDRin) or from memory (rd_req), and writes its own contents to memory
// (wr_req) with byte/half/word/dword lane selection and sign/zero extension.
// All outputs are registered.
// Optional feature macro: MDR_TIMEOUT_EN -- when defined, a wait that sees no
// mem_ready for TIMEOUT_CYC consecutive cycles is aborted with an err pulse.
// Ports:
//   clk        in  1         rising-edge clock
//   clr        in  1         synchronous active-high clear
//   BusMuxOut  in  DATA_W    bus data for MDRin loads
//   MDRin      in  1         load Q from BusMuxOut
//   rd_req     in  1         start memory read into Q
//   wr_req     in  1         start memory write from Q
//   size       in  2         00 byte, 01 half, 10 word, 11 dword
//   sign_ext   in  1         sign (1) or zero (0) extension on reads
//   lane_off   in  LANE_W    byte offset within memory word
//   mem_rdata  in  DATA_W    memory read data
//   mem_ready  in  1         memory completes current access
//   mem_rd     out 1         read strobe, held until ready
//   mem_wr     out 1         write strobe, held until ready
//   mem_wdata  out DATA_W    lane-aligned write data
//   mem_be     out DATA_W/8  byte enables
//   Q          out DATA_W    register contents
//   busy       out 1         high in wait states
//   done       out 1         one-cycle completion pulse
//   err        out 1         one-cycle error pulse (misalign / timeout)
// -----------------------------------------------------------------------------
module mdr_handshake
   import mdr_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int LANE_W      = $clog2(DATA_W/8),
   parameter int TIMEOUT_CYC = 15
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic [DATA_W-1:0]     BusMuxOut,
   input  logic                  MDRin,
   input  logic                  rd_req,
   input  logic                  wr_req,
   input  logic [1:0]            size,
   input  logic                  sign_ext,
   input  logic [LANE_W-1:0]     lane_off,
   input  logic [DATA_W-1:0]     mem_rdata,
   input  logic                  mem_ready,
   output logic                  mem_rd,
   output logic                  mem_wr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_be,
   output logic [DATA_W-1:0]     Q,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int NB = DATA_W / 8;

   mdr_state_e          state_q;
   logic [DATA_W-1:0]   q_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [NB-1:0]       be_q;
   logic                mem_rd_q;
   logic                mem_wr_q;
   logic                busy_q;
   logic                done_q;
   logic                err_q;
   logic [1:0]          size_q;
   logic                sext_q;
   logic [LANE_W-1:0]   off_q;

`ifdef MDR_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0]    cnt_q;
`endif

   // Request decode, evaluated against the live inputs in IDLE
   logic [1:0]          req_size_d;
   logic [2:0]          req_off_d;
   logic [3:0]          req_nb_d;
   logic [7:0]          req_be_full_d;
   logic                misalign_d;
   logic [NB-1:0]       be_d;
   logic [DATA_W-1:0]   size_mask_d;
   logic [DATA_W-1:0]   wdata_d;
   logic [DATA_W-1:0]   rd_ext;

   always_comb begin
      req_size_d = size;
      // A 32-bit register has no dword; it degrades to a word access.
      if (DATA_W == 32 && size == SZ_DWORD) req_size_d = SZ_WORD;
      req_off_d     = 3'(lane_off);
      req_nb_d      = size_bytes(req_size_d);
      req_be_full_d = be_mask(req_size_d, req_off_d);
      // Misaligned when the offset is not a multiple of the byte count, or
      // (defensively) when the enables would run past the top lane.
      misalign_d    = ((req_off_d & 3'(req_nb_d - 4'd1)) != 3'd0) ||
                      ((req_be_full_d >> NB) != 8'd0);
      be_d          = req_be_full_d[NB-1:0];
      for (int i = 0; i < DATA_W; i++) begin
         size_mask_d[i] = (i < 8 * int'(req_nb_d));
      end
      wdata_d = (q_q & size_mask_d) << {lane_off, 3'b000};
   end

   // Read path uses the captured access parameters, not the live inputs
   mdr_extend #(
      .DATA_W (DATA_W),
      .LANE_W (LANE_W)
   ) u_extend (
      .data_i     (mem_rdata),
      .size_i     (size_q),
      .sign_ext_i (sext_q),
      .lane_off_i (off_q),
      .data_o     (rd_ext)
   );

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q  <= IDLE;
         q_q      <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         mem_rd_q <= 1'b0;
         mem_wr_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         size_q   <= SZ_BYTE;
         sext_q   <= 1'b0;
         off_q    <= '0;
`ifdef MDR_TIMEOUT_EN
         cnt_q    <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rd_req || wr_req) begin
                  if (misalign_d) begin
                     err_q <= 1'b1;
                  end else begin
                     size_q <= req_size_d;
                     sext_q <= sign_ext;
                     off_q  <= lane_off;
                     busy_q <= 1'b1;
`ifdef MDR_TIMEOUT_EN
                     cnt_q  <= '0;
`endif
                     if (rd_req) begin
                        state_q  <= RD_WAIT;
                        mem_rd_q <= 1'b1;
                     end else begin
                        state_q  <= WR_WAIT;
                        mem_wr_q <= 1'b1;
                        wdata_q  <= wdata_d;
                        be_q     <= be_d;
                     end
                  end
               end else if (MDRin) begin
                  q_q <= BusMuxOut;
               end
            end
            RD_WAIT, WR_WAIT: begin
               if (mem_ready) begin
                  if (state_q == RD_WAIT) q_q <= rd_ext;
                  done_q   <= 1'b1;
                  state_q  <= IDLE;
                  mem_rd_q <= 1'b0;
                  mem_wr_q <= 1'b0;
                  busy_q   <= 1'b0;
                  wdata_q  <= '0;
                  be_q     <= '0;
               end
`ifdef MDR_TIMEOUT_EN
               // Ready on the last counted cycle is handled above and wins.
               else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                  err_q    <= 1'b1;
                  state_q  <= IDLE;
                  mem_rd_q <= 1'b0;
                  mem_wr_q <= 1'b0;
                  busy_q   <= 1'b0;
                  wdata_q  <= '0;
                  be_q     <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
`endif
            end
            default: begin
               state_q  <= IDLE;
               mem_rd_q <= 1'b0;
               mem_wr_q <= 1'b0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign Q         = q_q;
   assign mem_rd    = mem_rd_q;
   assign mem_wr    = mem_wr_q;
   assign mem_wdata = wdata_q;
   assign mem_be    = be_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_mdr_handshake.sv
module tb_mdr_handshake;

   logic        clk = 1'b0;
   logic        clr;
   logic [31:0] BusMuxOut;
   logic        MDRin;
   logic        rd_req;
   logic        wr_req;
   logic [1:0]  size;
   logic        sign_ext;
   logic [1:0]  lane_off;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] Q;
   logic        busy;
   logic        done;
   logic        err;

   int n_assert = 0;
   int n_fail   = 0;

   mdr_handshake #(
      .DATA_W      (32),
      .TIMEOUT_CYC (4)
   ) dut (
      .clk       (clk),
      .clr       (clr),
      .BusMuxOut (BusMuxOut),
      .MDRin     (MDRin),
      .rd_req    (rd_req),
      .wr_req    (wr_req),
      .size      (size),
      .sign_ext  (sign_ext),
      .lane_off  (lane_off),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .Q         (Q),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      clr = 1'b1; BusMuxOut = '0; MDRin = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
      size = 2'b00; sign_ext = 1'b0; lane_off = 2'd0; mem_rdata = '0; mem_ready = 1'b0;

      // reset state
      tick();
      chk("rst_Q", Q, 32'h0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
      chk("rst_pulses", {30'd0, done, err}, 32'd0);
      chk("rst_be", {28'd0, mem_be}, 32'd0);
      clr = 1'b0;

      // bus load
      BusMuxOut = 32'hDEADBEEF; MDRin = 1'b1;
      tick();
      MDRin = 1'b0;
      chk("mdrin_Q", Q, 32'hDEADBEEF);
      chk("mdrin_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);

      // signed byte read, lane 3, ready in third wait cycle
      size = 2'b00; sign_ext = 1'b1; lane_off = 2'd3; rd_req = 1'b1;
      mem_rdata = 32'h80FF0000;
      tick();
      rd_req = 1'b0; size = 2'b10; sign_ext = 1'b0; lane_off = 2'd0;
      chk("rd_strobe", {30'd0, mem_rd, busy}, 32'd3);
      chk("rd_Q_hold", Q, 32'hDEADBEEF);
      tick();
      tick();
      chk("rd_wait", {29'd0, mem_rd, busy, done}, 32'd6);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk("rd_sext_Q", Q, 32'hFFFFFF80);
      chk("rd_done", {29'd0, done, mem_rd, busy}, 32'd4);
      tick();
      chk("rd_done_once", {31'd0, done}, 32'd0);

      // same read, zero extension
      size = 2'b00; sign_ext = 1'b0; lane_off = 2'd3; rd_req = 1'b1;
      tick();
      rd_req = 1'b0; mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk("rd_zext_Q", Q, 32'h00000080);
      chk("rd_zext_done", {31'd0, done}, 32'd1);

      // half write at lane 2
      BusMuxOut = 32'h00001234; MDRin = 1'b1;
      tick();
      MDRin = 1'b0;
      size = 2'b01; lane_off = 2'd2; wr_req = 1'b1;
      tick();
      wr_req = 1'b0; size = 2'b00; lane_off = 2'd1;
      chk("wr_wdata", mem_wdata, 32'h12340000);
      chk("wr_be", {28'd0, mem_be}, 32'b1100);
      chk("wr_strobe", {29'd0, mem_wr, mem_rd, busy}, 32'b101);
      tick();
      chk("wr_hold", {31'd0, mem_wr}, 32'd1);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk("wr_done", {29'd0, done, mem_wr, busy}, 32'b100);
      chk("wr_Q_unch", Q, 32'h00001234);

      // byte write at lane 1
      size = 2'b00; lane_off = 2'd1; wr_req = 1'b1;
      tick();
      wr_req = 1'b0;
      chk("wrb_wdata", mem_wdata, 32'h00003400);
      chk("wrb_be", {28'd0, mem_be}, 32'b0010);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk("wrb_done", {31'd0, done}, 32'd1);

      // misaligned half read at lane 1
      size = 2'b01; lane_off = 2'd1; rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("mis_err", {30'd0, err, done}, 32'b10);
      chk("mis_nostrobe", {29'd0, mem_rd, mem_wr, busy}, 32'd0);
      chk("mis_Q", Q, 32'h00001234);
      tick();
      chk("mis_err_once", {31'd0, err}, 32'd0);

      // dword on 32-bit behaves as word: lane 2 is misaligned
      size = 2'b11; lane_off = 2'd2; rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("dw_mis_err", {30'd0, err, mem_rd}, 32'b10);

      // priority: rd beats wr and MDRin; dword lane 0 acts as word
      BusMuxOut = 32'hCAFEF00D; MDRin = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
      size = 2'b11; lane_off = 2'd0; sign_ext = 1'b1; mem_rdata = 32'h11223344;
      tick();
      MDRin = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
      chk("prio_strobe", {30'd0, mem_rd, mem_wr}, 32'b10);
      chk("prio_Q_noload", Q, 32'h00001234);
      mem_ready = 1'b1;
      tick();
      chk("prio_Q", Q, 32'h11223344);
      chk("prio_done", {31'd0, done}, 32'd1);

      // mem_ready in IDLE does nothing
      mem_rdata = 32'h55555555;
      tick();
      mem_ready = 1'b0;
      chk("idle_ready", {30'd0, done, busy}, 32'd0);
      chk("idle_ready_Q", Q, 32'h11223344);

      // clear in RD_WAIT
      size = 2'b10; lane_off = 2'd0; rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      chk("clr_pre", {31'd0, mem_rd}, 32'd1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_Q", Q, 32'h0);
      chk("clr_ctrl", {29'd0, busy, mem_rd, done}, 32'd0);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk("clr_late_ready", Q, 32'h0);
      chk("clr_late_done", {30'd0, done, mem_rd}, 32'd0);

`ifdef MDR_TIMEOUT_EN
      // timeout after 4 wait cycles
      mem_rdata = 32'hA5A5A5A5; size = 2'b10; lane_off = 2'd0; rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      tick(); tick(); tick();
      chk("to_pre", {30'd0, err, mem_rd}, 32'b01);
      tick();
      chk("to_err", {28'd0, err, done, mem_rd, busy}, 32'b1000);
      chk("to_Q", Q, 32'h0);
      tick();
      chk("to_err_once", {31'd0, err}, 32'd0);

      // ready on the 4th wait cycle wins
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      tick(); tick(); tick();
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk("to_win", {30'd0, done, err}, 32'b10);
      chk("to_win_Q", Q, 32'hA5A5A5A5);
`else
      // without timeout the wait is unbounded
      mem_rdata = 32'hA5A5A5A5; size = 2'b10; lane_off = 2'd0; rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      repeat (20) tick();
      chk("nto_wait", {29'd0, err, mem_rd, busy}, 32'b011);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      chk("nto_done", {30'd0, done, err}, 32'b10);
      chk("nto_Q", Q, 32'hA5A5A5A5);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
